midi_out: RTL and testbench

MIDI output encoder and UART transmitter: accepts one channel-voice event per handshake, builds the MIDI message (status + data bytes, with optional running status) and serialises it at 31250 baud, 8N1, on a single TX line. It sits beside the MIDI input path as the return direction, so the synth can echo or generate MIDI toward external gear. Clocked from the 50 MHz board clock.

---
 rtl/midi_out.sv | 142 ++++++++++++++
 tb/tb_midi_out.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/midi_out.sv
// rtl/midi_out.sv - MIDI channel-voice encoder with 8N1 UART transmitter
// Message FSM walks status/data bytes; the bit phase/baud counters serialise the current byte.
module midi_out #(
  parameter int CLKS_PER_BIT   = 1600,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       IN_CLOCK,
  input  logic       IN_RESET,
  input  logic       IN_VALID,
  output logic       OUT_READY,
  input  logic [1:0] IN_KIND,
  input  logic [3:0] IN_CHANNEL,
  input  logic [6:0] IN_DATA1,
  input  logic [6:0] IN_DATA2,
  output logic       OUT_TX,
  output logic       OUT_BUSY,
  output logic       OUT_BYTE_SENT
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {M_IDLE, M_STATUS, M_D1, M_D2} msg_t;
  typedef enum logic [1:0] {B_START, B_DATA, B_STOP} phase_t;

  msg_t          r_msg, w_msg_next;
  phase_t        r_phase, w_phase_next;
  logic [CW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_status;
  logic [6:0]    r_d1, r_d2;
  logic          r_two_byte;
  logic [7:0]    r_last_status;
  logic          r_last_valid;

  logic [2:0]    w_opcode;
  logic [7:0]    w_status;
  logic          w_accept;
  logic          w_skip_status;
  logic          w_baud_end;
  logic          w_byte_end;
  logic [7:0]    w_cur_byte;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_msg         <= M_IDLE;
      r_phase       <= B_START;
      r_baud        <= '0;
      r_bit         <= '0;
      r_status      <= '0;
      r_d1          <= '0;
      r_d2          <= '0;
      r_two_byte    <= 1'b0;
      r_last_status <= '0;
      r_last_valid  <= 1'b0;
    end else begin
      r_msg   <= w_msg_next;
      r_phase <= w_phase_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      if (w_accept) begin
        r_status   <= w_status;
        r_d1       <= IN_DATA1;
        r_d2       <= IN_DATA2;
        r_two_byte <= (IN_KIND == 2'd3);
      end
      // Running status only becomes valid once its status byte has fully left the wire.
      if (w_byte_end && (r_msg == M_STATUS)) begin
        r_last_status <= r_status;
        r_last_valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_opcode = 3'b000;
    case (IN_KIND)
      2'd0:    w_opcode = 3'b000;
      2'd1:    w_opcode = 3'b001;
      2'd2:    w_opcode = 3'b011;
      default: w_opcode = 3'b100;
    endcase
    w_status      = {1'b1, w_opcode, IN_CHANNEL};
    w_accept      = IN_VALID && (r_msg == M_IDLE);
    w_skip_status = RUNNING_STATUS && r_last_valid && (r_last_status == w_status);
    w_baud_end    = (r_baud == BAUD_LAST);
    w_byte_end    = (r_msg != M_IDLE) && (r_phase == B_STOP) && w_baud_end;

    w_cur_byte = 8'h00;
    case (r_msg)
      M_STATUS: w_cur_byte = r_status;
      M_D1:     w_cur_byte = {1'b0, r_d1};
      M_D2:     w_cur_byte = {1'b0, r_d2};
      default:  w_cur_byte = 8'h00;
    endcase

    w_msg_next = r_msg;
    case (r_msg)
      M_IDLE:   if (w_accept) w_msg_next = w_skip_status ? M_D1 : M_STATUS;
      M_STATUS: if (w_byte_end) w_msg_next = M_D1;
      M_D1:     if (w_byte_end) w_msg_next = r_two_byte ? M_IDLE : M_D2;
      M_D2:     if (w_byte_end) w_msg_next = M_IDLE;
      default:  w_msg_next = M_IDLE;
    endcase

    w_phase_next = r_phase;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    if (w_accept) begin
      w_phase_next = B_START;
      w_baud_next  = '0;
      w_bit_next   = '0;
    end else if (r_msg != M_IDLE) begin
      if (w_baud_end) begin
        w_baud_next = '0;
        case (r_phase)
          B_START: w_phase_next = B_DATA;
          B_DATA: begin
            w_bit_next = r_bit + 3'd1;
            if (r_bit == 3'd7) w_phase_next = B_STOP;
          end
          default: w_phase_next = B_START;
        endcase
      end else begin
        w_baud_next = r_baud + CW'(1);
      end
    end

    OUT_READY     = (r_msg == M_IDLE);
    OUT_BUSY      = (r_msg != M_IDLE);
    OUT_BYTE_SENT = w_byte_end;
    OUT_TX        = 1'b1;
    if (r_msg != M_IDLE) begin
      case (r_phase)
        B_START: OUT_TX = 1'b0;
        B_DATA:  OUT_TX = w_cur_byte[r_bit];
        default: OUT_TX = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_out.sv
// tb/tb_midi_out.sv - scoreboard bench for midi_out, running-status and always-status instances
module tb_midi_out;
  localparam int CPB      = 16;
  localparam int BYTE_CYC = 10 * CPB;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid;
  logic [1:0] kind;
  logic [3:0] ch;
  logic [6:0] d1, d2;
  logic [1:0] ready, tx, busy, bsent;

  midi_out #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) u_dut_rs (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_VALID(valid), .OUT_READY(ready[0]),
    .IN_KIND(kind), .IN_CHANNEL(ch), .IN_DATA1(d1), .IN_DATA2(d2),
    .OUT_TX(tx[0]), .OUT_BUSY(busy[0]), .OUT_BYTE_SENT(bsent[0])
  );

  midi_out #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) u_dut_full (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_VALID(valid), .OUT_READY(ready[1]),
    .IN_KIND(kind), .IN_CHANNEL(ch), .IN_DATA1(d1), .IN_DATA2(d2),
    .OUT_TX(tx[1]), .OUT_BUSY(busy[1]), .OUT_BYTE_SENT(bsent[1])
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [2][$];
  int         exp_cnt [2];
  int         pulse_cnt [2];
  bit         rx_on [2];
  int         rx_n [2];
  logic [7:0] rx_b [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver per instance: decodes bytes from TX and pops the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rx_on[d] = 1'b0;
      end else begin
        if (!rx_on[d]) begin
          if (tx[d] == 1'b0) begin
            rx_on[d] = 1'b1;
            rx_n[d]  = 0;
          end
        end else begin
          rx_n[d]++;
        end
        if (bsent[d] && !(rx_on[d] && rx_n[d] == BYTE_CYC - 1))
          check($sformatf("byte_sent_spurious%0d", d), 32'(bsent[d]), 32'd0);
        if (rx_on[d] && rx_n[d] > 0) begin
          if (rx_n[d] >= CPB && rx_n[d] < 9 * CPB && (rx_n[d] % CPB) == CPB / 2)
            rx_b[d][rx_n[d] / CPB - 1] = tx[d];
          if (rx_n[d] == 9 * CPB + CPB / 2)
            check($sformatf("stop_bit%0d", d), 32'(tx[d]), 32'd1);
          if (rx_n[d] == BYTE_CYC - 1) begin
            check($sformatf("byte_sent_pulse%0d", d), 32'(bsent[d]), 32'd1);
            if (bsent[d]) pulse_cnt[d]++;
            if (exp_q[d].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_byte%0d: got 0x%02h expected none", d, rx_b[d]);
            end else begin
              check($sformatf("tx_byte%0d", d), 32'(rx_b[d]), 32'(exp_q[d].pop_front()));
            end
            rx_on[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_bytes(input int d, input int n, input logic [23:0] e);
    for (int i = 0; i < n; i++) begin
      exp_q[d].push_back(e[23 - 8 * i -: 8]);
      exp_cnt[d]++;
    end
  endtask

  // Called at a negedge with both instances idle; returns at a negedge with both idle again.
  task automatic issue(input logic [1:0] k, input logic [3:0] c, input logic [6:0] a,
                       input logic [6:0] b, input int n0, input logic [23:0] e0,
                       input int n1, input logic [23:0] e1);
    int done0, done1, mism;
    kind = k; ch = c; d1 = a; d2 = b; valid = 1'b1;
    push_bytes(0, n0, e0);
    push_bytes(1, n1, e1);
    @(negedge clk);
    valid = 1'b0;
    check("ready_drop", 32'(ready), 32'd0);
    check("start_bit", 32'(tx), 32'd0);
    done0 = 0; done1 = 0; mism = 0;
    for (int cyc = 1; cyc <= 4 * BYTE_CYC; cyc++) begin
      if (busy !== ~ready) mism++;
      if (done0 == 0 && ready[0]) done0 = cyc;
      if (done1 == 0 && ready[1]) done1 = cyc;
      if (done0 != 0 && done1 != 0) break;
      @(negedge clk);
    end
    check("busy_cycles_rs", 32'(done0 - 1), 32'(n0 * BYTE_CYC));
    check("busy_cycles_full", 32'(done1 - 1), 32'(n1 * BYTE_CYC));
    check("busy_vs_ready", 32'(mism), 32'd0);
  endtask

  initial begin
    int rise;
    rst = 1'b1; valid = 1'b0; kind = '0; ch = '0; d1 = '0; d2 = '0;
    for (int d = 0; d < 2; d++) begin
      exp_cnt[d] = 0; pulse_cnt[d] = 0; rx_on[d] = 1'b0; rx_n[d] = 0; rx_b[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'd3);
    check("reset_ready", 32'(ready), 32'd3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_byte_sent", 32'(bsent), 32'd0);

    issue(2'd1, 4'd0, 7'd60, 7'd100, 3, 24'h903C64, 3, 24'h903C64);
    issue(2'd1, 4'd0, 7'd64, 7'd0,   2, 24'h400000, 3, 24'h904000);
    issue(2'd0, 4'd5, 7'd60, 7'd64,  3, 24'h853C40, 3, 24'h853C40);
    issue(2'd3, 4'd2, 7'd7,  7'd99,  2, 24'hC20700, 2, 24'hC20700);
    issue(2'd3, 4'd2, 7'd7,  7'd99,  1, 24'h070000, 2, 24'hC20700);

    // abort in the second data bit of the second byte; only the status byte completes
    kind = 2'd1; ch = 4'd1; d1 = 7'd60; d2 = 7'd100; valid = 1'b1;
    push_bytes(0, 1, 24'h910000);
    push_bytes(1, 1, 24'h910000);
    @(negedge clk);
    valid = 1'b0;
    repeat (200) @(negedge clk);
    check("pre_abort_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd3);
    check("abort_ready", 32'(ready), 32'd3);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'd1, 4'd1, 7'd60, 7'd100, 3, 24'h913C64, 3, 24'h913C64);

    // valid held through a whole message while the fields change
    kind = 2'd1; ch = 4'd3; d1 = 7'd10; d2 = 7'd20; valid = 1'b1;
    push_bytes(0, 3, 24'h930A14);
    push_bytes(1, 3, 24'h930A14);
    @(negedge clk);
    check("held_accept", 32'(ready), 32'd0);
    kind = 2'd2; d1 = 7'd7; d2 = 7'd5;
    push_bytes(0, 3, 24'hB30705);
    push_bytes(1, 3, 24'hB30705);
    rise = 0;
    for (int cyc = 1; cyc <= 4 * BYTE_CYC; cyc++) begin
      if (ready[0]) begin
        rise = cyc;
        break;
      end
      @(negedge clk);
    end
    check("held_busy_cycles", 32'(rise - 1), 32'(3 * BYTE_CYC));
    check("held_ready_full", 32'(ready[1]), 32'd1);
    @(negedge clk);
    check("held_reaccept_ready", 32'(ready), 32'd0);
    check("held_reaccept_start", 32'(tx), 32'd0);
    valid = 1'b0;
    rise = 0;
    for (int cyc = 1; cyc <= 4 * BYTE_CYC; cyc++) begin
      if (ready[0]) begin
        rise = cyc;
        break;
      end
      @(negedge clk);
    end
    check("second_busy_cycles", 32'(rise - 1), 32'(3 * BYTE_CYC));

    for (int i = 0; i < 4 * BYTE_CYC; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !rx_on[0] && !rx_on[1]) break;
      @(negedge clk);
    end
    repeat (2 * BYTE_CYC) @(negedge clk);
    check("drain_rs", 32'(exp_q[0].size()), 32'd0);
    check("drain_full", 32'(exp_q[1].size()), 32'd0);
    check("pulse_count_rs", 32'(pulse_cnt[0]), 32'(exp_cnt[0]));
    check("pulse_count_full", 32'(pulse_cnt[1]), 32'(exp_cnt[1]));
    check("idle_tx", 32'(tx), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
